controller_regs: RTL and testbench
==================================

CONTROLLER_REGS -- requirements
Module: controller_regs

Interface
REQ-001 Parameter NUM_CONTROLLERS, default 2: number of controller ports.
REQ-002 Parameter START_CYCLES, default 2: start_fetch_o pulse length in clocks; legal range 1..9.
REQ-003 Parameter SETTLE_CYCLES, default 16: clocks from the end of the start pulse until the serial fetch result is sampled.
REQ-004 Parameter ADDR_W, default $clog2(NUM_CONTROLLERS*4).
REQ-005 clk  in  1: single clock for all logic.
REQ-006 rst_ni  in  1: reset, asynchronous, active-low.
REQ-007 vblank_i  in  1: vertical blank level, synchronous to clk.
REQ-008 start_fetch_o  out  1: fetch request to the serial controller interface.
REQ-009 data_LIST_i  in  NUM_CONTROLLERS x 8: parallel button bytes from the serial controller interface; 1 = pressed.
REQ-010 rd_en_i  in  1: CPU read strobe, one clock per access.
REQ-011 addr_i  in  ADDR_W: register address.
REQ-012 rdata_o  out  8: read data, registered.

Function
REQ-013 The block SHALL run an FSM with states IDLE, START, SETTLE and UPDATE.
REQ-014 IDLE->START on a vblank_i rising edge, detected against a registered copy of vblank_i; rising edges seen in any other state SHALL be ignored, not queued.
REQ-015 START SHALL drive start_fetch_o=1 for exactly START_CYCLES clocks, then go to SETTLE with start_fetch_o=0.
REQ-016 SETTLE SHALL count SETTLE_CYCLES clocks, then go to UPDATE.
REQ-017 UPDATE SHALL last one clock and then return to IDLE.
REQ-018 In the UPDATE clock, for each controller c:
- prev[c] <= cur[c]
- cur[c] <= data_LIST_i[c]
- pressed[c] <= pressed[c] | (data_LIST_i[c] & ~cur[c])
- released[c] <= released[c] | (~data_LIST_i[c] & cur[c])
REQ-019 Register map: address = c*4 + offset.
- offset 0: cur
- offset 1: pressed, read-to-clear
- offset 2: released, read-to-clear
- offset 3: {7'b0, busy}, where busy = (state != IDLE)
REQ-020 When rd_en_i=1, rdata_o SHALL update on the next clk edge with the addressed value (latency 1); when rd_en_i=0, rdata_o SHALL hold its value.
REQ-021 An address with c >= NUM_CONTROLLERS SHALL read 8'h00 and have no side effect.
REQ-022 A read of offset 1 or 2 SHALL return the pre-clear value and clear that register on the same edge.
REQ-023 If a read-clear and an UPDATE hit the same register on the same edge, the new edge bits from UPDATE SHALL be written (clear of the old bits, set of the new bits); no new edge SHALL be lost.
REQ-024 Sticky bits SHALL accumulate across multiple UPDATEs until read.
REQ-025 All arithmetic is 8-bit bitwise; the counters SHALL be wide enough for max(START_CYCLES, SETTLE_CYCLES) and SHALL NOT wrap.

Reset
REQ-026 While rst_ni=0, independent of clk, the block SHALL hold:
- FSM = IDLE, counters = 0
- start_fetch_o = 0, rdata_o = 8'h00
- cur, prev, pressed, released = 8'h00
- registered vblank_i = 1 (vblank high at reset release SHALL NOT trigger a fetch)
REQ-027 Reset asserted mid-fetch SHALL abort the fetch immediately; the next fetch SHALL start only on a new vblank_i rising edge.

Verification
REQ-028 vblank_i 0->1 with data_LIST_i[0]=8'h81 -> start_fetch_o high for 2 clocks, cur[0]=8'h81 exactly 2+16+1 clocks after the edge, pressed[0]=8'h81.
REQ-029 Second fetch with data_LIST_i[0]=8'h01 and no read in between -> released[0]=8'h80, pressed[0] still 8'h81; reading address 1 returns 8'h81, and the next read returns 8'h00.
REQ-030 Read of address 1 on the UPDATE edge, with old pressed=8'h01 and new edge 8'h02 -> rdata_o=8'h01, and pressed=8'h02 afterwards.
REQ-031 vblank_i toggled 0->1->0->1 during SETTLE -> exactly one fetch occurs; address 3 reads 8'h01 while busy and 8'h00 in IDLE.
REQ-032 rst_ni pulsed low during SETTLE -> start_fetch_o=0 and all registers 8'h00 immediately, with no UPDATE afterwards; read of address 8 (NUM_CONTROLLERS=2) -> 8'h00.

Source files
------------

// File: rtl/controller_regs.sv
// controller_regs: vblank-triggered serial controller fetch sequencer with
// per-controller current/pressed/released button registers on a CPU read port.
module controller_regs #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int START_CYCLES = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int ADDR_W = $clog2(NUM_CONTROLLERS * 4)
) (
    input  logic                             clk,
    input  logic                             rst_ni,
    input  logic                             vblank_i,
    output logic                             start_fetch_o,
    input  logic [NUM_CONTROLLERS-1:0][7:0] data_LIST_i,
    input  logic                             rd_en_i,
    input  logic [ADDR_W-1:0]                addr_i,
    output logic [7:0]                       rdata_o
);
    localparam int MAX_CYC = START_CYCLES > SETTLE_CYCLES ? START_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);
    typedef enum logic [1:0] {IDLE, START, SETTLE, UPDATE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic vblank_q;
    logic [NUM_CONTROLLERS-1:0][7:0] cur, prev, pressed, released;
    logic [NUM_CONTROLLERS-1:0] clr_p, clr_r;
    logic [31:0] sel;
    logic [1:0] off;
    logic [7:0] rd_val;
    logic upd;
    // prev is retained state with no register-map slot
    logic unused_prev;
    assign unused_prev = ^prev;
    assign sel = 32'(addr_i >> 2);
    assign off = addr_i[1:0];
    assign upd = state == UPDATE;
    always_comb begin
        rd_val = 8'h00;
        clr_p = '0;
        clr_r = '0;
        for (int c = 0; c < NUM_CONTROLLERS; c++) begin
            if (sel == c) begin
                rd_val = off == 2'd0 ? cur[c] : off == 2'd1 ? pressed[c] :
                         off == 2'd2 ? released[c] : {7'b0, state != IDLE};
                clr_p[c] = rd_en_i && off == 2'd1;
                clr_r[c] = rd_en_i && off == 2'd2;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt <= '0;
            vblank_q <= 1'b1;
            start_fetch_o <= 1'b0;
            rdata_o <= 8'h00;
            cur <= '0;
            prev <= '0;
            pressed <= '0;
            released <= '0;
        end else begin
            vblank_q <= vblank_i;
            if (rd_en_i) rdata_o <= rd_val;
            // a read-clear on the UPDATE edge drops old bits but keeps the new edges
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                pressed[c] <= (clr_p[c] ? 8'h00 : pressed[c]) | (upd ? data_LIST_i[c] & ~cur[c] : 8'h00);
                released[c] <= (clr_r[c] ? 8'h00 : released[c]) | (upd ? ~data_LIST_i[c] & cur[c] : 8'h00);
            end
            if (upd) begin
                prev <= cur;
                cur <= data_LIST_i;
            end
            case (state)
                IDLE: if (vblank_i && !vblank_q) begin
                    state <= START;
                    start_fetch_o <= 1'b1;
                    cnt <= '0;
                end
                START: if (cnt == CW'(START_CYCLES - 1)) begin
                    state <= SETTLE;
                    start_fetch_o <= 1'b0;
                    cnt <= '0;
                end else cnt <= cnt + CW'(1);
                SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state <= UPDATE;
                    cnt <= '0;
                end else cnt <= cnt + CW'(1);
                UPDATE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controller_regs.sv
// tb_controller_regs: directed and randomized checks of controller_regs
// against a register-level behavioural model.
module tb_controller_regs;
    logic clk = 1'b0, rst_ni = 1'b0, vblank = 1'b0, start, rd_en = 1'b0;
    logic [1:0][7:0] data = '0;
    logic [3:0] addr = '0;
    logic [7:0] rdata;
    int checks = 0, errors = 0;
    logic [7:0] m_cur [2], m_pr [2], m_rl [2];
    logic m_busy = 1'b0;
    logic [7:0] last_exp;

    controller_regs #(.NUM_CONTROLLERS(2), .START_CYCLES(2), .SETTLE_CYCLES(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_ni(rst_ni), .vblank_i(vblank), .start_fetch_o(start),
        .data_LIST_i(data), .rd_en_i(rd_en), .addr_i(addr), .rdata_o(rdata));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cur[c] = 8'h00; m_pr[c] = 8'h00; m_rl[c] = 8'h00;
        end
        m_busy = 1'b0;
    endtask

    // value a read returns, with its read-to-clear side effect applied
    task automatic model_read(input logic [3:0] a, output logic [7:0] v);
        int c;
        c = int'(a) / 4;
        v = 8'h00;
        if (c < 2) begin
            case (a % 4)
                0: v = m_cur[c];
                1: begin v = m_pr[c]; m_pr[c] = 8'h00; end
                2: begin v = m_rl[c]; m_rl[c] = 8'h00; end
                default: v = {7'b0, m_busy};
            endcase
        end
    endtask

    task automatic model_update(input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] d [2];
        d[0] = d0; d[1] = d1;
        for (int c = 0; c < 2; c++) begin
            m_pr[c] |= d[c] & ~m_cur[c];
            m_rl[c] |= ~d[c] & m_cur[c];
            m_cur[c] = d[c];
        end
    endtask

    task automatic rd(input logic [3:0] a);
        logic [7:0] e;
        addr = a;
        rd_en = 1'b1;
        model_read(a, e);
        tick();
        rd_en = 1'b0;
        last_exp = e;
        chk($sformatf("read@%0d", a), rdata, e);
    endtask

    // one complete fetch; optionally a read lands on the UPDATE edge
    task automatic fetch(input logic [7:0] d0, input logic [7:0] d1, input bit rd_upd, input logic [3:0] ra);
        logic [7:0] e;
        data[0] = d0; data[1] = d1;
        vblank = 1'b1;
        tick();
        chk("start_first", {7'b0, start}, 8'h01);
        tick();
        chk("start_second", {7'b0, start}, 8'h01);
        tick();
        chk("start_end", {7'b0, start}, 8'h00);
        repeat (16) tick();
        e = 8'h00;
        m_busy = 1'b1;
        if (rd_upd) begin
            addr = ra;
            rd_en = 1'b1;
            model_read(ra, e);
        end
        model_update(d0, d1);
        tick();
        rd_en = 1'b0;
        m_busy = 1'b0;
        if (rd_upd) chk($sformatf("upd_read@%0d", ra), rdata, e);
        vblank = 1'b0;
        tick();
    endtask

    initial begin
        int starts;
        model_reset();
        #2;
        chk("rst_start", {7'b0, start}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        tick();
        rst_ni = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) rd(4'(a));

        // 0x81 pressed; cur read on the UPDATE edge is still the old value
        fetch(8'h81, 8'h00, 1'b1, 4'd0);
        rd(0); rd(4);
        addr = 4'd2;
        tick();
        chk("rdata_hold", rdata, last_exp);
        fetch(8'h01, 8'h00, 1'b0, 4'd0);
        rd(2); rd(1); rd(1); rd(0);

        // clear and new edge on the same edge
        fetch(8'h00, 8'h00, 1'b0, 4'd0);
        fetch(8'h01, 8'h00, 1'b0, 4'd0);
        fetch(8'h03, 8'h00, 1'b1, 4'd1);
        rd(1); rd(2);

        // vblank bouncing during the fetch must not queue a second one
        data[0] = 8'h3C; data[1] = 8'hA5;
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            vblank = (i < 5) || (i >= 8 && i < 12) || i >= 14;
            rd_en = (i == 10) || (i == 30);
            addr = 4'd3;
            tick();
            rd_en = 1'b0;
            if (start) starts++;
            if (i == 10) chk("busy_settle", rdata, 8'h01);
            if (i == 30) chk("busy_idle", rdata, 8'h00);
        end
        chk("one_fetch", 8'(starts), 8'd2);
        model_update(8'h3C, 8'hA5);
        vblank = 1'b0;
        tick();
        rd(0); rd(4); rd(5); rd(6);

        // reset in SETTLE aborts the fetch; vblank high at release is not an edge
        rd(0);
        data[0] = 8'hFF; data[1] = 8'hFF;
        vblank = 1'b1;
        repeat (8) tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("abort_start", {7'b0, start}, 8'h00);
        chk("abort_rdata", rdata, 8'h00);
        model_reset();
        tick();
        tick();
        rst_ni = 1'b1;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start) starts++;
        end
        chk("no_fetch_after_rst", 8'(starts), 8'd0);
        for (int a = 0; a < 16; a++) rd(4'(a));
        vblank = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) begin
            fetch(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            repeat (3) rd(4'($urandom));
        end
        for (int a = 0; a < 8; a++) rd(4'(a));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
